// File: rtl/alu_pipe_if.sv
// Handshake bundle between the decode stage, the pipelined ALU and writeback.
// The master drives operands and accepts results; the slave is the ALU.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       opcode;
    logic             ext_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             a_is_zero;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic [15:0]      op_count;

    modport master (
        output in_valid, in_a, in_b, opcode, ext_en, out_ready,
        input  in_ready, out_valid, alu_out, a_is_zero, zero, carry, overflow, op_count
    );

    modport slave (
        input  in_valid, in_a, in_b, opcode, ext_en, out_ready,
        output in_ready, out_valid, alu_out, a_is_zero, zero, carry, overflow, op_count
    );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined VeriRISC-compatible ALU: legacy and extended opcode banks, stored carry for
// multi-word arithmetic, result flags, valid/ready on both sides, one or two register stages.
module alu_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    localparam int unsigned MSB = WIDTH - 1;

    // {ext_en, opcode}
    localparam logic [3:0] OpAdd  = 4'b0_010;
    localparam logic [3:0] OpAnd  = 4'b0_011;
    localparam logic [3:0] OpXor  = 4'b0_100;
    localparam logic [3:0] OpPassB = 4'b0_101;
    localparam logic [3:0] OpSub  = 4'b1_000;
    localparam logic [3:0] OpOr   = 4'b1_001;
    localparam logic [3:0] OpAddc = 4'b1_010;
    localparam logic [3:0] OpNand = 4'b1_011;
    localparam logic [3:0] OpXnor = 4'b1_100;
    localparam logic [3:0] OpShl  = 4'b1_101;
    localparam logic [3:0] OpShr  = 4'b1_110;
    localparam logic [3:0] OpRol  = 4'b1_111;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             a_zero;
        logic             zero;
        logic             carry;
        logic             ovf;
    } result_t;

    logic           carry_q;
    logic           s1_valid_q;
    result_t        s1_q;
    logic           s1_adv;
    logic           out_valid;
    result_t        out_q;
    logic [15:0]    op_count_q;

    logic           in_ready;
    logic           accept;
    logic           upd_carry;
    logic           add_cin;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           add_ovf;
    logic           sub_ovf;
    result_t        r;

    assign in_ready = !s1_valid_q || s1_adv;
    assign accept   = bus.in_valid && in_ready;

    // ADDC always consumes the carry of the latest accepted carry-producing op.
    assign add_cin = ({bus.ext_en, bus.opcode} == OpAddc) ? carry_q : 1'b0;
    assign sum     = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {{WIDTH{1'b0}}, add_cin};
    assign diff    = {1'b0, bus.in_a} - {1'b0, bus.in_b};
    assign add_ovf = (bus.in_a[MSB] == bus.in_b[MSB]) && (sum[MSB] != bus.in_a[MSB]);
    assign sub_ovf = (bus.in_a[MSB] != bus.in_b[MSB]) && (diff[MSB] != bus.in_a[MSB]);

    always_comb begin
        r         = '0;
        upd_carry = 1'b0;
        case ({bus.ext_en, bus.opcode})
            OpAdd, OpAddc: begin
                r.res     = sum[WIDTH-1:0];
                r.carry   = sum[WIDTH];
                r.ovf     = add_ovf;
                upd_carry = 1'b1;
            end
            OpAnd:   r.res = bus.in_a & bus.in_b;
            OpXor:   r.res = bus.in_a ^ bus.in_b;
            OpPassB: r.res = bus.in_b;
            OpSub: begin
                r.res     = diff[WIDTH-1:0];
                r.carry   = diff[WIDTH];
                r.ovf     = sub_ovf;
                upd_carry = 1'b1;
            end
            OpOr:    r.res = bus.in_a | bus.in_b;
            OpNand:  r.res = ~(bus.in_a & bus.in_b);
            OpXnor:  r.res = ~(bus.in_a ^ bus.in_b);
            OpShl: begin
                r.res     = {bus.in_a[WIDTH-2:0], 1'b0};
                r.carry   = bus.in_a[MSB];
                upd_carry = 1'b1;
            end
            OpShr: begin
                r.res     = {1'b0, bus.in_a[WIDTH-1:1]};
                r.carry   = bus.in_a[0];
                upd_carry = 1'b1;
            end
            OpRol: begin
                r.res     = {bus.in_a[WIDTH-2:0], bus.in_a[MSB]};
                r.carry   = bus.in_a[MSB];
                upd_carry = 1'b1;
            end
            default: r.res = bus.in_a;
        endcase
        r.a_zero = (bus.in_a == '0);
        r.zero   = (r.res == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else if (accept && upd_carry) begin
            carry_q <= r.carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_q       <= r;
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    generate
        if (STAGES == 2) begin : g_two_stage
            logic    s2_valid_q;
            result_t s2_q;

            assign s1_adv = !s2_valid_q || bus.out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid_q <= 1'b0;
                    s2_q       <= '0;
                end else if (s1_valid_q && s1_adv) begin
                    s2_valid_q <= 1'b1;
                    s2_q       <= s1_q;
                end else if (bus.out_ready) begin
                    s2_valid_q <= 1'b0;
                end
            end

            assign out_valid = s2_valid_q;
            assign out_q     = s2_q;
        end else begin : g_one_stage
            assign s1_adv    = bus.out_ready;
            assign out_valid = s1_valid_q;
            assign out_q     = s1_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else if (out_valid && bus.out_ready) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.alu_out   = out_q.res;
    assign bus.a_is_zero = out_q.a_zero;
    assign bus.zero      = out_q.zero;
    assign bus.carry     = out_q.carry;
    assign bus.overflow  = out_q.ovf;
    assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors push hand-computed results, a monitor
// pops and compares on every output transfer.
module tb_alu_pipe;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 2;

    typedef struct packed {
        logic [7:0] res;
        logic       a_zero;
        logic       zero;
        logic       carry;
        logic       ovf;
    } exp_t;

    typedef struct {
        string name;
        exp_t  e;
        int    acc_cyc;
        bit    chk_lat;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(WIDTH)) bus ();

    alu_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sb_t  exp_q[$];
    sb_t  mon_s;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_issued = 0;
    int   nacc = 0;
    int   cyc_start = 0;
    bit   lat_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Called at a falling edge; holds the vector until accepted, then returns at a falling edge.
    task automatic send(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic ext,
                        input logic [7:0] er, input logic ec, input logic ev);
        bit  acc = 1'b0;
        sb_t s;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.opcode   = op;
        bus.ext_en   = ext;
        for (int t = 0; t < 100 && !acc; t++) begin
            #4;
            if (bus.in_ready) begin
                acc       = 1'b1;
                s.name    = name;
                s.e       = {er, (a == 8'h00), (er == 8'h00), ec, ev};
                s.acc_cyc = cyc;
                s.chk_lat = lat_mode;
                exp_q.push_back(s);
                n_issued++;
            end
            @(negedge clk);
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: in_ready never rose within 100 cycles", name);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.opcode   = 3'bxxx;
        bus.ext_en   = 1'bx;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    // Monitor: compare every output transfer against the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", bus.out_valid, 0);
                end else begin
                    mon_s = exp_q.pop_front();
                    check(mon_s.name, {bus.alu_out, bus.a_is_zero, bus.zero, bus.carry,
                                       bus.overflow}, mon_s.e);
                    if (mon_s.chk_lat) check({mon_s.name, "_latency"}, cyc - mon_s.acc_cyc, STAGES);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.out_ready = 1'b1;
        bus.in_a      = '0;
        bus.in_b      = '0;
        idle();
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_alu_out", bus.alu_out, 0);
        check("rst_flags", {bus.a_is_zero, bus.zero, bus.carry, bus.overflow}, 0);
        check("rst_op_count", bus.op_count, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);

        // Legacy bank sweep, back to back
        lat_mode  = 1'b1;
        cyc_start = cyc;
        send("leg000", 8'hC3, 8'h5A, 3'b000, 1'b0, 8'hC3, 1'b0, 1'b0);
        send("leg001", 8'hC3, 8'h5A, 3'b001, 1'b0, 8'hC3, 1'b0, 1'b0);
        send("leg010", 8'hC3, 8'h5A, 3'b010, 1'b0, 8'h1D, 1'b1, 1'b0);
        send("leg011", 8'hC3, 8'h5A, 3'b011, 1'b0, 8'h42, 1'b0, 1'b0);
        send("leg100", 8'hC3, 8'h5A, 3'b100, 1'b0, 8'h99, 1'b0, 1'b0);
        send("leg101", 8'hC3, 8'h5A, 3'b101, 1'b0, 8'h5A, 1'b0, 1'b0);
        send("leg110", 8'hC3, 8'h5A, 3'b110, 1'b0, 8'hC3, 1'b0, 1'b0);
        send("leg111", 8'hC3, 8'h5A, 3'b111, 1'b0, 8'hC3, 1'b0, 1'b0);
        check("sweep_throughput", cyc - cyc_start, 8);
        lat_mode = 1'b0;

        // Multi-word add, subtract/overflow, shifts, remaining extended ops
        send("add_ff01",  8'hFF, 8'h01, 3'b010, 1'b0, 8'h00, 1'b1, 1'b0);
        send("addc_0000", 8'h00, 8'h00, 3'b010, 1'b1, 8'h01, 1'b0, 1'b0);
        send("sub_8001",  8'h80, 8'h01, 3'b000, 1'b1, 8'h7F, 1'b0, 1'b1);
        send("sub_0102",  8'h01, 8'h02, 3'b000, 1'b1, 8'hFF, 1'b1, 1'b0);
        send("shl_81",    8'h81, 8'h00, 3'b101, 1'b1, 8'h02, 1'b1, 1'b0);
        send("shr_81",    8'h81, 8'h00, 3'b110, 1'b1, 8'h40, 1'b1, 1'b0);
        send("rol_81",    8'h81, 8'h00, 3'b111, 1'b1, 8'h03, 1'b1, 1'b0);
        send("addc_1020", 8'h10, 8'h20, 3'b010, 1'b1, 8'h31, 1'b0, 1'b0);
        send("or_0ff0",   8'h0F, 8'hF0, 3'b001, 1'b1, 8'hFF, 1'b0, 1'b0);
        send("nand_ff0f", 8'hFF, 8'h0F, 3'b011, 1'b1, 8'hF0, 1'b0, 1'b0);
        send("xnor_aa0f", 8'hAA, 8'h0F, 3'b100, 1'b1, 8'h5A, 1'b0, 1'b0);
        send("sub_7fff",  8'h7F, 8'hFF, 3'b000, 1'b1, 8'h80, 1'b1, 1'b1);
        send("add_4040",  8'h40, 8'h40, 3'b010, 1'b0, 8'h80, 1'b0, 1'b1);
        idle();
        drain("directed");

        // Backpressure: consumer stalls for 5 cycles under continuous input
        bus.out_ready = 1'b0;
        nacc = 0;
        fork
            begin
                send("bp0", 8'h01, 8'h11, 3'b101, 1'b0, 8'h11, 1'b0, 1'b0);
                send("bp1", 8'h02, 8'h22, 3'b101, 1'b0, 8'h22, 1'b0, 1'b0);
                send("bp2", 8'h03, 8'h33, 3'b101, 1'b0, 8'h33, 1'b0, 1'b0);
                send("bp3", 8'h04, 8'h44, 3'b101, 1'b0, 8'h44, 1'b0, 1'b0);
                send("bp4", 8'h05, 8'h55, 3'b101, 1'b0, 8'h55, 1'b0, 1'b0);
                send("bp5", 8'h06, 8'h66, 3'b101, 1'b0, 8'h66, 1'b0, 1'b0);
                idle();
            end
            begin
                for (int c = 0; c < 5; c++) begin
                    #4;
                    if (bus.in_valid && bus.in_ready) nacc++;
                    if (bus.out_valid) check("bp_hold_alu_out", bus.alu_out, 8'h11);
                    if (c == 4) check("bp_in_ready_low", bus.in_ready, 0);
                    @(negedge clk);
                end
                check("bp_accepts", nacc, STAGES);
                bus.out_ready = 1'b1;
            end
        join
        drain("backpressure");
        check("op_count_total", bus.op_count, n_issued);

        // Reset with two results in flight
        send("rst0", 8'hFF, 8'h01, 3'b010, 1'b0, 8'h00, 1'b1, 1'b0);
        send("rst1", 8'h12, 8'h34, 3'b101, 1'b0, 8'h34, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_op_count", bus.op_count, 0);
        exp_q.delete();
        n_issued = 0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", bus.in_ready, 1);
        repeat (4) @(negedge clk);
        send("addc_after_rst", 8'h00, 8'h00, 3'b010, 1'b1, 8'h00, 1'b0, 1'b0);
        idle();
        drain("post_reset");

        // op_count wrap
        for (int i = 0; i < 65534; i++) begin
            send("wrap_fill", 8'h5A, i[7:0], 3'b101, 1'b0, i[7:0], 1'b0, 1'b0);
        end
        idle();
        drain("wrap_fill");
        check("op_count_ffff", bus.op_count, 16'hFFFF);
        send("wrap_last", 8'h00, 8'h77, 3'b101, 1'b0, 8'h77, 1'b0, 1'b0);
        idle();
        drain("wrap_last");
        check("op_count_wrap", bus.op_count, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
